// File: rtl/light_pkg.sv
// Shared types and constants for the light sampler: curtain command codes,
// FSM state encodings and default hysteresis thresholds.
package light_pkg;

  typedef enum logic [1:0] {
    CMD_HOLD  = 2'b00,
    CMD_OPEN  = 2'b01,
    CMD_CLOSE = 2'b10
  } cmd_t;

  typedef enum logic [1:0] {
    ADC_IDLE,
    ADC_CS_SETUP,
    ADC_SHIFT,
    ADC_CONV
  } adc_state_t;

  typedef enum logic [1:0] {
    CTRL_IDLE,
    CTRL_XFER,
    CTRL_UPDATE
  } ctrl_state_t;

  localparam logic [7:0] TH_HIGH_DEF = 8'd180;
  localparam logic [7:0] TH_LOW_DEF  = 8'd80;

  // Strict comparisons: a value equal to either threshold keeps the old command.
  function automatic logic [1:0] next_cmd(input logic [7:0] lvl, input logic [7:0] hi,
                                          input logic [7:0] lo, input logic [1:0] prev);
    if (lvl > hi) return CMD_CLOSE;
    if (lvl < lo) return CMD_OPEN;
    return prev;
  endfunction

endpackage

// File: rtl/light_sample_ctrl_if.sv
// Serial ADC bus (TLC549-style): chip select, serial clock and data out.
interface light_sample_ctrl_if;
  logic adc_cs_n;
  logic adc_sclk;
  logic adc_sdo;

  modport master (output adc_cs_n, output adc_sclk, input adc_sdo);
  modport slave  (input adc_cs_n, input adc_sclk, output adc_sdo);
endinterface

// File: rtl/light_sample_ctrl_adc_serial_rx.sv
// One ADC read: cs setup, 8 MSB-first bits on a divided sclk, then a
// conversion wait with cs high. Pulses done with the byte at the end.
module adc_serial_rx
  import light_pkg::*;
#(
  parameter int unsigned SCLK_DIV  = 8,
  parameter int unsigned CONV_WAIT = 136
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  output logic                done,
  output logic [7:0]          data,
  light_sample_ctrl_if.master adc
);

  localparam int unsigned CNT_MAX = (CONV_WAIT > 2 * SCLK_DIV) ? CONV_WAIT : 2 * SCLK_DIV;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] SETUP_END = CNT_W'(2 * SCLK_DIV - 1);
  localparam logic [CNT_W-1:0] HALF_END  = CNT_W'(SCLK_DIV - 1);
  localparam logic [CNT_W-1:0] CONV_END  = CNT_W'(CONV_WAIT - 1);

  adc_state_t       state;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       bit_cnt;
  logic [7:0]       sr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ADC_IDLE;
      cnt          <= '0;
      bit_cnt      <= '0;
      sr           <= '0;
      data         <= '0;
      done         <= 1'b0;
      adc.adc_cs_n <= 1'b1;
      adc.adc_sclk <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ADC_IDLE: begin
          if (start) begin
            state        <= ADC_CS_SETUP;
            cnt          <= '0;
            adc.adc_cs_n <= 1'b0;
          end
        end
        ADC_CS_SETUP: begin
          if (cnt == SETUP_END) begin
            state   <= ADC_SHIFT;
            cnt     <= '0;
            bit_cnt <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ADC_SHIFT: begin
          if (cnt == HALF_END) begin
            cnt <= '0;
            if (!adc.adc_sclk) begin
              adc.adc_sclk <= 1'b1;
              sr           <= {sr[6:0], adc.adc_sdo};
            end else begin
              adc.adc_sclk <= 1'b0;
              if (bit_cnt == 3'd7) begin
                adc.adc_cs_n <= 1'b1;
                state        <= ADC_CONV;
              end else begin
                bit_cnt <= bit_cnt + 1'b1;
              end
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ADC_CONV: begin
          if (cnt == CONV_END) begin
            state <= ADC_IDLE;
            done  <= 1'b1;
            data  <= sr;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= ADC_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/light_sample_ctrl.sv
// Tick-driven light sampler with ADC priming and hysteresis curtain command.
// Optional 4-sample running average when LIGHT_AVG_EN is defined.
module light_sample_ctrl
  import light_pkg::*;
#(
  parameter int unsigned SCLK_DIV  = 8,
  parameter int unsigned CONV_WAIT = 136,
  parameter logic [7:0]  TH_HIGH   = TH_HIGH_DEF,
  parameter logic [7:0]  TH_LOW    = TH_LOW_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                tick,
  light_sample_ctrl_if.master adc,
  output logic [7:0]          light,
  output logic                light_vld,
  output logic [1:0]          cmd,
  output logic                busy
);

  ctrl_state_t state;
  logic        tick_d;
  logic        start_q;
  logic        prime_done;
  logic        start;
  logic        done;
  logic        publish;
  logic [7:0]  data;
  logic [7:0]  new_light;

  // The post-priming read is chained combinationally so it starts on the
  // very cycle done is seen, saving one cycle against a fresh tick.
  assign start   = start_q | (state == CTRL_XFER && done && !prime_done);
  assign publish = (state == CTRL_XFER) && done && prime_done;

  adc_serial_rx #(
    .SCLK_DIV  (SCLK_DIV),
    .CONV_WAIT (CONV_WAIT)
  ) u_rx (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .done  (done),
    .data  (data),
    .adc   (adc)
  );

`ifdef LIGHT_AVG_EN
  logic [7:0] hist [4];
  logic [1:0] wr_ptr;
  logic [9:0] sum;
  logic [9:0] sum_next;
  logic       hist_vld;

  always_comb begin
    sum_next = {data, 2'b00};
    if (hist_vld) sum_next = sum - 10'(hist[wr_ptr]) + 10'(data);
  end

  assign new_light = sum_next[9:2];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist     <= '{default: '0};
      wr_ptr   <= '0;
      sum      <= '0;
      hist_vld <= 1'b0;
    end else if (publish) begin
      sum <= sum_next;
      if (!hist_vld) begin
        hist     <= '{default: data};
        hist_vld <= 1'b1;
      end else begin
        hist[wr_ptr] <= data;
        wr_ptr       <= wr_ptr + 1'b1;
      end
    end
  end
`else
  assign new_light = data;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= CTRL_IDLE;
      tick_d     <= 1'b0;
      start_q    <= 1'b0;
      prime_done <= 1'b0;
      light      <= '0;
      light_vld  <= 1'b0;
      cmd        <= CMD_HOLD;
      busy       <= 1'b0;
    end else begin
      tick_d    <= tick;
      start_q   <= 1'b0;
      light_vld <= 1'b0;
      case (state)
        CTRL_IDLE: begin
          if (tick && !tick_d) begin
            state   <= CTRL_XFER;
            start_q <= 1'b1;
            busy    <= 1'b1;
          end
        end
        CTRL_XFER: begin
          if (done) begin
            if (!prime_done) begin
              prime_done <= 1'b1;
            end else begin
              light     <= new_light;
              light_vld <= 1'b1;
              cmd       <= next_cmd(new_light, TH_HIGH, TH_LOW, cmd);
              state     <= CTRL_UPDATE;
            end
          end
        end
        CTRL_UPDATE: begin
          state <= CTRL_IDLE;
          busy  <= 1'b0;
        end
        default: state <= CTRL_IDLE;
      endcase
    end
  end

endmodule
